ibex_data_sram_bridge: RTL

- Sits between the ibex core data port and the 1 KB sky130 SRAM macro (32x256, rw port 0).
- Replaces the hard-wired data rvalid with a real req/gnt/rvalid protocol.
- Decodes an address window and flags out-of-range accesses as bus errors.
- Scrubs the SRAM to zero after reset before granting any core access.

---
 rtl/ibex_data_sram_pkg.sv | 25 ++
 rtl/ibex_data_sram_decode.sv | 27 ++
 rtl/ibex_data_sram_bridge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ibex_data_sram_pkg.sv
// ibex_data_sram_pkg
//   Shared types and constants for the ibex data-side SRAM bridge and its
//   address decoder.
//   Contents:
//     state_e      - bridge FSM states (INIT, READY)
//     SRAM_BYTES   - byte size of the default 256-word macro
//     ERR_RDATA    - read data returned for writes and bus errors
//     sram_bytes() - byte size of a window of a given word depth
package ibex_data_sram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned SRAM_BYTES = 4 * 256;

    localparam logic [31:0] ERR_RDATA = 32'h0;

    // 33 bits so that a window covering the full 4 GB space still compares correctly
    function automatic logic [32:0] sram_bytes(input int unsigned depth);
        return 33'(depth) << 2;
    endfunction

endpackage

// File: rtl/ibex_data_sram_decode.sv
// ibex_data_sram_decode
//   Combinational address-window decoder. Shared by the data and instruction
//   side bridges.
//   Ports:
//     i_addr  in  32  byte address from the core
//     o_hit   out 1   address lies inside [BASE_ADDR, BASE_ADDR + 4*DEPTH)
//     o_waddr out AW  SRAM word address (byte offset bits dropped)
module ibex_data_sram_decode
    import ibex_data_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned AW        = 8
) (
    input  logic [31:0]   i_addr,
    output logic          o_hit,
    output logic [AW-1:0] o_waddr
);

    logic [31:0] w_off;

    // Unsigned subtract: addresses below BASE wrap to a large offset and miss.
    assign w_off   = i_addr - BASE_ADDR;
    assign o_hit   = {1'b0, w_off} < sram_bytes(DEPTH);
    assign o_waddr = w_off[AW+1:2];

endmodule

// File: rtl/ibex_data_sram_bridge.sv
// ibex_data_sram_bridge
//   Bridges the ibex data port to a single-port 32-bit SRAM macro with a
//   req/gnt/rvalid handshake, zero wait states and a fixed one-cycle response.
//   After reset the SRAM is zero-filled (INIT_EN=1) before any grant is given.
//   Ports:
//     clk, reset           clock and asynchronous active-high reset
//     data_*               ibex data-side request/response interface
//     sram_*               SRAM macro rw port 0 (active-low csb/web)
//     init_done_o          scrub complete, bridge accepting requests
module ibex_data_sram_bridge
    import ibex_data_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = SRAM_BYTES / 4,
    parameter int unsigned AW        = 8,
    parameter bit          INIT_EN   = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_req_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,
    output logic          sram_csb_o,
    output logic          sram_web_o,
    output logic [3:0]    sram_wmask_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_din_o,
    input  logic [31:0]   sram_dout_i,
    output logic          init_done_o
);

    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    state_e        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_init_done;
    logic          r_rvalid;
    logic          r_err;
    logic          r_rd_hit;
    logic [31:0]   r_hold;

    logic          w_hit;
    logic [AW-1:0] w_waddr;
    logic          w_fill;
    logic          w_gnt;
    logic [31:0]   w_resp_data;

    ibex_data_sram_decode #(
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_decode (
        .i_addr  (data_addr_i),
        .o_hit   (w_hit),
        .o_waddr (w_waddr)
    );

    // The SRAM strobes are qualified with reset so the macro is deselected
    // while reset is held, even though the state register already sits in INIT.
    assign w_fill = !reset && (r_state == INIT);
    assign w_gnt  = !reset && (r_state == READY) && data_req_i;

    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_wmask_o = 4'h0;
        sram_addr_o  = '0;
        sram_din_o   = 32'h0;
        if (w_fill) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = 1'b0;
            sram_wmask_o = 4'hF;
            sram_addr_o  = r_cnt;
        end else if (w_gnt && w_hit) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~data_we_i;
            sram_wmask_o = data_be_i;
            sram_addr_o  = w_waddr;
            sram_din_o   = data_wdata_i;
        end
    end

    // SRAM read data is only meaningful the cycle after a hit read.
    assign w_resp_data = r_rd_hit ? sram_dout_i : ERR_RDATA;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= INIT_EN ? INIT : READY;
            r_cnt       <= '0;
            r_init_done <= !INIT_EN;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_rd_hit    <= 1'b0;
            r_hold      <= 32'h0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == LAST_WORD) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    r_state <= READY;
                end
                default: r_state <= INIT;
            endcase
            r_rvalid <= w_gnt;
            r_err    <= w_gnt && !w_hit;
            r_rd_hit <= w_gnt && w_hit && !data_we_i;
            if (r_rvalid) begin
                r_hold <= w_resp_data;
            end
        end
    end

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = r_rvalid;
    assign data_err_o    = r_err;
    assign data_rdata_o  = r_rvalid ? w_resp_data : r_hold;
    assign init_done_o   = r_init_done;

endmodule
